// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction encoder: the operation
// enumeration, the 6-bit opcode and funct constants, memory depth and
// word-building helpers.
package isa_pkg;

  localparam int unsigned IMEM_DEPTH = 256;
  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned COUNT_W    = 9;

  // Operation codes as presented on in_op; 10-15 are illegal.
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SLT  = 4'd4,
    OP_LW   = 4'd5,
    OP_SW   = 4'd6,
    OP_BEQ  = 4'd7,
    OP_BNE  = 4'd8,
    OP_ADDI = 4'd9
  } op_e;

  // Primary opcode field values.
  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;

  // R-type funct field values.
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Load sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } enc_state_e;

  // R-type word: opcode 0, rs, rt, rd, shamt 0, funct.
  function automatic logic [31:0] rtype_word(input logic [4:0] rs,
                                             input logic [4:0] rt,
                                             input logic [4:0] rd,
                                             input logic [5:0] funct);
    return {OPC_RTYPE, rs, rt, rd, 5'd0, funct};
  endfunction

  // I-type word: opcode, rs, rt, 16-bit immediate.
  function automatic logic [31:0] itype_word(input logic [5:0]  opc,
                                             input logic [4:0]  rs,
                                             input logic [4:0]  rt,
                                             input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field-to-word mapping: turns an operation and its register
// and immediate fields into a 32-bit instruction word, and flags ops that
// have no encoding.
module instr_pack
  import isa_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [15:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_legal
);

  // Select the word format and constant fields from the operation.
  always_comb begin
    o_word  = '0;
    o_legal = 1'b1;
    case (op_e'(i_op))
      OP_ADD:  o_word = rtype_word(i_rs, i_rt, i_rd, FN_ADD);
      OP_SUB:  o_word = rtype_word(i_rs, i_rt, i_rd, FN_SUB);
      OP_AND:  o_word = rtype_word(i_rs, i_rt, i_rd, FN_AND);
      OP_OR:   o_word = rtype_word(i_rs, i_rt, i_rd, FN_OR);
      OP_SLT:  o_word = rtype_word(i_rs, i_rt, i_rd, FN_SLT);
      OP_LW:   o_word = itype_word(OPC_LW,   i_rs, i_rt, i_imm);
      OP_SW:   o_word = itype_word(OPC_SW,   i_rs, i_rt, i_imm);
      OP_BEQ:  o_word = itype_word(OPC_BEQ,  i_rs, i_rt, i_imm);
      OP_BNE:  o_word = itype_word(OPC_BNE,  i_rs, i_rt, i_imm);
      OP_ADDI: o_word = itype_word(OPC_ADDI, i_rs, i_rt, i_imm);
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program-load sequencer: accepts instruction fields one per cycle while a
// load is open, encodes them and writes them to consecutive instruction
// memory words with a one-cycle registered write port. Tracks the number
// of words written, stops accepting once the memory is full, and keeps
// sticky flags for illegal operations and overflow attempts.
module instr_encoder
  import isa_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [15:0] in_imm,
  input  logic        in_last,
  output logic        imem_we,
  output logic [7:0]  imem_addr,
  output logic [31:0] imem_wdata,
  output logic        done,
  output logic        err_illegal,
  output logic        err_overflow,
  output logic [8:0]  count
);

  localparam logic [COUNT_W-1:0] LAST_SLOT = COUNT_W'(IMEM_DEPTH - 1);

  enc_state_e          r_state;
  logic                r_ready;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic                r_done;
  logic                r_err_illegal;
  logic                r_err_overflow;
  logic [COUNT_W-1:0]  r_count;

  logic [31:0]         w_word;
  logic                w_legal;
  logic                w_accept;

  instr_pack u_pack (
    .i_op    (in_op),
    .i_rs    (in_rs),
    .i_rt    (in_rt),
    .i_rd    (in_rd),
    .i_imm   (in_imm),
    .o_word  (w_word),
    .o_legal (w_legal)
  );

  assign w_accept = in_valid && r_ready;

  // State, write-port register, word counter and sticky error flags.
  // in_ready is held as its own register and updated on every state change
  // so it always equals (state == LOAD) without a decode after the flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_ready        <= 1'b0;
      r_we           <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_done         <= 1'b0;
      r_err_illegal  <= 1'b0;
      r_err_overflow <= 1'b0;
      r_count        <= '0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      if (load_start) begin
        // A new load wins over any transfer offered in the same cycle.
        r_state        <= ST_LOAD;
        r_ready        <= 1'b1;
        r_count        <= '0;
        r_addr         <= '0;
        r_err_illegal  <= 1'b0;
        r_err_overflow <= 1'b0;
      end else begin
        case (r_state)
          ST_LOAD: begin
            if (w_accept) begin
              if (w_legal) begin
                r_we    <= 1'b1;
                r_addr  <= r_count[ADDR_W-1:0];
                r_wdata <= w_word;
                r_count <= r_count + 1'b1;
              end else begin
                r_err_illegal <= 1'b1;
              end
              if (in_last) begin
                r_done  <= 1'b1;
                r_state <= ST_IDLE;
                r_ready <= 1'b0;
              end else if (w_legal && (r_count == LAST_SLOT)) begin
                r_state <= ST_FULL;
                r_ready <= 1'b0;
              end
            end
          end
          ST_FULL: begin
            if (in_valid) begin
              r_err_overflow <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign in_ready     = r_ready;
  assign imem_we      = r_we;
  assign imem_addr    = r_addr;
  assign imem_wdata   = r_wdata;
  assign done         = r_done;
  assign err_illegal  = r_err_illegal;
  assign err_overflow = r_err_overflow;
  assign count        = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: directed scenarios plus randomized loads,
// every cycle compared against a behavioural model of the load rules.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [15:0] in_imm;
  logic        in_last;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        done;
  logic        err_illegal;
  logic        err_overflow;
  logic [8:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: mode 0 idle, 1 loading, 2 memory full.
  int          m_mode = 0;
  int          m_cnt  = 0;
  bit          m_ei   = 0;
  bit          m_eo   = 0;
  bit          e_we   = 0;
  bit          e_done = 0;
  int          e_addr = 0;
  logic [31:0] e_data = '0;

  instr_encoder dut (
    .clk          (clk),
    .reset        (reset),
    .load_start   (load_start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_rs        (in_rs),
    .in_rt        (in_rt),
    .in_rd        (in_rd),
    .in_imm       (in_imm),
    .in_last      (in_last),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .done         (done),
    .err_illegal  (err_illegal),
    .err_overflow (err_overflow),
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Instruction word built from field weights and numeric opcode/funct values.
  function automatic logic [31:0] ref_encode(int op, int rs, int rt, int rd, int imm);
    longint w;
    int f;
    int opc;
    if (op <= 4) begin
      case (op)
        0: f = 32;
        1: f = 34;
        2: f = 36;
        3: f = 37;
        default: f = 42;
      endcase
      w = longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048 + f;
    end else begin
      case (op)
        5: opc = 35;
        6: opc = 43;
        7: opc = 4;
        8: opc = 5;
        default: opc = 8;
      endcase
      w = longint'(opc) * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536 + imm;
    end
    return w[31:0];
  endfunction

  // Predict the outputs that follow the coming clock edge.
  task automatic model_step();
    e_we   = 0;
    e_done = 0;
    if (reset) begin
      m_mode = 0; m_cnt = 0; m_ei = 0; m_eo = 0; e_addr = 0; e_data = '0;
    end else if (load_start) begin
      m_mode = 1; m_cnt = 0; m_ei = 0; m_eo = 0; e_addr = 0;
    end else if (m_mode == 1 && in_valid) begin
      if (int'(in_op) <= 9) begin
        e_we   = 1;
        e_addr = m_cnt;
        e_data = ref_encode(int'(in_op), int'(in_rs), int'(in_rt), int'(in_rd), int'(in_imm));
        m_cnt++;
      end else begin
        m_ei = 1;
      end
      if (in_last) begin
        e_done = 1;
        m_mode = 0;
      end else if (m_cnt == 256) begin
        m_mode = 2;
      end
    end else if (m_mode == 2 && in_valid) begin
      m_eo = 1;
    end
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_eq({tag, ":in_ready"}, 32'(in_ready), 32'(m_mode == 1));
    check_eq({tag, ":imem_we"}, 32'(imem_we), 32'(e_we));
    check_eq({tag, ":done"}, 32'(done), 32'(e_done));
    check_eq({tag, ":err_illegal"}, 32'(err_illegal), 32'(m_ei));
    check_eq({tag, ":err_overflow"}, 32'(err_overflow), 32'(m_eo));
    check_eq({tag, ":count"}, 32'(count), 32'(m_cnt));
    if (e_we || reset) begin
      check_eq({tag, ":imem_addr"}, 32'(imem_addr), 32'(e_addr));
      check_eq({tag, ":imem_wdata"}, imem_wdata, e_data);
    end
  endtask

  task automatic drive(input bit ls, input bit v, input int op, input int rs, input int rt,
                       input int rd, input int imm, input bit last);
    load_start = ls;
    in_valid   = v;
    in_op      = 4'(op);
    in_rs      = 5'(rs);
    in_rt      = 5'(rt);
    in_rd      = 5'(rd);
    in_imm     = 16'(imm);
    in_last    = last;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_legal(input bit last);
    drive(0, 1, $urandom_range(0, 9), $urandom_range(0, 31), $urandom_range(0, 31),
          $urandom_range(0, 31), $urandom_range(0, 65535), last);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    step("rst0");
    step("rst1");
    check_eq("rst:imem_addr", 32'(imem_addr), 32'd0);
    check_eq("rst:imem_wdata", imem_wdata, 32'd0);
    reset = 1'b0;

    // IDLE ignores in_valid and flags nothing.
    drive(0, 1, 12, 1, 1, 1, 1, 1);
    step("idle_valid");

    // Single ADD with in_last.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    step("add_ls");
    drive(0, 1, 0, 1, 2, 3, 0, 1);
    step("add");
    check_eq("add:word", imem_wdata, 32'h00221820);
    check_eq("add:addr", 32'(imem_addr), 32'd0);
    check_eq("add:done", 32'(done), 32'd1);
    check_eq("add:count", 32'(count), 32'd1);
    idle();
    step("add_after");

    // Back-to-back LW then BEQ.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    step("b2b_ls");
    drive(0, 1, 5, 0, 8, 0, 4, 0);
    step("lw");
    check_eq("lw:word", imem_wdata, 32'h8C080004);
    check_eq("lw:addr", 32'(imem_addr), 32'd0);
    drive(0, 1, 7, 8, 9, 0, 16'hFFFF, 0);
    step("beq");
    check_eq("beq:word", imem_wdata, 32'h1109FFFF);
    check_eq("beq:addr", 32'(imem_addr), 32'd1);

    // Illegal op mid-load, then a legal op at the unchanged address.
    drive(0, 1, 12, 3, 3, 3, 3, 0);
    step("illegal");
    check_eq("illegal:we", 32'(imem_we), 32'd0);
    check_eq("illegal:err", 32'(err_illegal), 32'd1);
    drive(0, 1, 1, 4, 5, 6, 0, 0);
    step("after_illegal");
    check_eq("after_illegal:addr", 32'(imem_addr), 32'd2);

    // load_start coincident with a transfer discards it and clears errors.
    drive(1, 1, 0, 7, 7, 7, 0, 0);
    step("ls_coincide");
    check_eq("ls_coincide:we", 32'(imem_we), 32'd0);
    check_eq("ls_coincide:count", 32'(count), 32'd0);
    check_eq("ls_coincide:err_illegal", 32'(err_illegal), 32'd0);
    check_eq("ls_coincide:err_overflow", 32'(err_overflow), 32'd0);

    // Fill all 256 words, then keep offering data while full.
    for (int i = 0; i < 256; i++) begin
      rand_legal(0);
      step("fill");
    end
    check_eq("full:count", 32'(count), 32'd256);
    check_eq("full:in_ready", 32'(in_ready), 32'd0);
    check_eq("full:last_addr", 32'(imem_addr), 32'd255);
    rand_legal(0);
    step("full_valid0");
    step("full_valid1");
    check_eq("full:err_overflow", 32'(err_overflow), 32'd1);
    check_eq("full:count_hold", 32'(count), 32'd256);

    // 256th write carrying in_last finishes the load instead of filling.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    step("fill_last_ls");
    for (int i = 0; i < 255; i++) begin
      rand_legal(0);
      step("fill2");
    end
    rand_legal(1);
    step("fill2_last");
    check_eq("fill_last:done", 32'(done), 32'd1);
    check_eq("fill_last:count", 32'(count), 32'd256);
    rand_legal(0);
    step("fill_last_idle");
    check_eq("fill_last:no_overflow", 32'(err_overflow), 32'd0);

    // Reset in the cycle after an accept drops the write.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    step("rst_ls");
    rand_legal(0);
    step("rst_accept");
    reset = 1'b1;
    rand_legal(0);
    step("rst_mid");
    check_eq("rst_mid:we", 32'(imem_we), 32'd0);
    check_eq("rst_mid:count", 32'(count), 32'd0);
    check_eq("rst_mid:in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    idle();
    step("rst_release");

    // Randomized loads with illegal ops, gaps, last markers and restarts.
    for (int i = 0; i < 3000; i++) begin
      bit ls;
      bit last;
      int op;
      ls   = (m_mode != 1) ? ($urandom_range(0, 99) < 20) : ($urandom_range(0, 99) < 2);
      last = ($urandom_range(0, 99) < 4);
      op   = ($urandom_range(0, 99) < 10) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      reset = ($urandom_range(0, 999) < 5);
      drive(ls, ($urandom_range(0, 3) != 0), op, $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 31), $urandom_range(0, 65535), last);
      step("rand");
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: load_start  in  1  one-cycle pulse that opens a program load.
REQ-004 SHALL have: in_valid  in  1  instruction fields present.
REQ-005 SHALL have: in_ready  out  1  encoder can accept this cycle.
REQ-006 SHALL have: in_op  in  4  operation code, 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 BEQ, 8 BNE, 9 ADDI, 10-15 illegal.
REQ-007 SHALL have: in_rs, in_rt, in_rd  in  5 each  register fields.
REQ-008 SHALL have: in_imm  in  16  immediate or branch offset.
REQ-009 SHALL have: in_last  in  1  marks final instruction of the load.
REQ-010 SHALL have: imem_we  out  1  instruction-memory write strobe.
REQ-011 SHALL have: imem_addr  out  8  word address.
REQ-012 SHALL have: imem_wdata  out  32  encoded instruction.
REQ-013 SHALL have: done  out  1  one-cycle pulse after the last write.
REQ-014 SHALL have: err_illegal  out  1  sticky, set by an illegal in_op.
REQ-015 SHALL have: err_overflow  out  1  sticky, set by an accept attempt in FULL.
REQ-016 SHALL have: count  out  9  words written in the current load, 0-256.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, FULL.
REQ-018 SHALL move to LOAD on load_start from any state; this clears count, the address pointer and both error flags.
REQ-019 SHALL drive in_ready=1 only in LOAD; a transfer occurs when in_valid and in_ready are both 1.
REQ-020 SHALL register each accepted transfer, so imem_we=1 exactly one cycle later with imem_addr=count before increment; this gives one accept per cycle and 1-cycle latency.
REQ-021 SHALL encode R-type words as opcode 000000 with rs, rt, rd, shamt 0 and funct ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
REQ-022 SHALL encode I-type words as {opcode, rs, rt, imm}, with opcodes LW 100011, SW 101011, BEQ 000100, BNE 000101, ADDI 001000.
REQ-023 SHALL consume an accepted illegal op without writing it: no imem_we, no count change, err_illegal set.
REQ-024 SHALL increment count on every imem_we; imem_addr wraps never occur because the 256th write moves the FSM to FULL.
REQ-025 SHALL return to IDLE when an accepted transfer has in_last=1, and SHALL pulse done in the same cycle as that transfer's imem_we, or its would-be write if the op was illegal.
REQ-026 SHALL move to FULL when count reaches 256, with in_ready=0; in_valid=1 in FULL sets err_overflow; an in_last arriving with the 256th write pulses done and moves to IDLE instead.
REQ-027 SHALL honour a load_start that coincides with a transfer: the transfer is discarded, no write occurs, and the new load begins.
REQ-028 SHALL hold in_ready=0 in IDLE and ignore in_valid there without flagging errors.

Reset
REQ-029 SHALL on reset enter IDLE with in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, done=0, err_illegal=0, err_overflow=0, count=0.
REQ-030 SHALL on reset during LOAD drop any pending registered write.

Structure
REQ-031 SHALL take the in_op enumeration, the 6-bit opcode constants, the funct constants and IMEM_DEPTH=256 from the shared package isa_pkg.
REQ-032 SHALL place the combinational field-to-word mapping in the sub-module instr_pack; the FSM, pipeline register and counter stay in instr_encoder.

Verification
REQ-033 The bench SHALL apply load_start, then ADD rs=1 rt=2 rd=3 with in_last, and check imem_wdata=0x00221820 at addr 0, done the same cycle, and count=1.
REQ-034 The bench SHALL stream LW rs=0 rt=8 imm=4 then BEQ rs=8 rt=9 imm=0xFFFF on back-to-back cycles, and check 0x8C080004 at addr 0 and 0x1109FFFF at addr 1.
REQ-035 The bench SHALL apply in_op=12 mid-load and check that no write occurs, err_illegal=1, and the next legal op lands at the unchanged address.
REQ-036 The bench SHALL write 256 ops without in_last, then hold in_valid, and check FULL, in_ready=0, err_overflow=1, and count=256.
REQ-037 The bench SHALL assert reset in the cycle after an accept and check imem_we=0 and all outputs at their reset values.
REQ-038 The bench SHALL pulse load_start coincident with a transfer in LOAD and check that no write occurs, count=0, and both errors are cleared.
